// File: rtl/keygen_mul_pkg.sv
// Shared widths, stage bounds and mode encoding for the keygen multiply/accumulate pipe.
package keygen_mul_pkg;

    localparam int A_WIDTH_DEF   = 13;
    localparam int B_WIDTH_DEF   = 9;
    localparam int P_WIDTH_DEF   = 13;
    localparam int NUM_STAGE_MIN = 2;
    localparam int NUM_STAGE_MAX = 8;
    localparam int CNT_WIDTH     = 8;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_ACC = 1'b1
    } mode_e;

    // Beat counter increment that sticks at the all-ones value.
    function automatic logic [CNT_WIDTH-1:0] satInc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/keygen_mul_delay.sv
// Width/depth parametrised register line with clock enable and async clear.
// A depth of zero collapses to a wire so the top can run with only two stages.
module keygen_mul_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unusedCtrl;
            assign unusedCtrl = clk ^ reset ^ ce;
            assign q_o = d_i;
        end else begin : g_line
            logic [WIDTH-1:0] line_q [DEPTH];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
                end else if (ce) begin
                    line_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
                end
            end

            assign q_o = line_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/keygen_mac_pipe.sv
// Pipelined multiplier with optional framed accumulation (first/last) and beat counting.
// Stage 1 registers inputs, middle stages carry the product, the last stage accumulates/outputs.
module keygen_mac_pipe
    import keygen_mul_pkg::*;
#(
    parameter int A_WIDTH   = A_WIDTH_DEF,
    parameter int B_WIDTH   = B_WIDTH_DEF,
    parameter int P_WIDTH   = P_WIDTH_DEF,
    parameter bit A_SIGNED  = 1'b1,
    parameter bit B_SIGNED  = 1'b0,
    parameter int NUM_STAGE = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic [A_WIDTH-1:0]   din0,
    input  logic [B_WIDTH-1:0]   din1,
    input  logic                 mode,
    input  logic                 first,
    input  logic                 last,
    output logic                 out_valid,
    output logic [P_WIDTH-1:0]   dout,
    output logic [CNT_WIDTH-1:0] out_count
);

    localparam int  FW       = A_WIDTH + B_WIDTH;
    localparam bit  SIGN_EXT = A_SIGNED || B_SIGNED;
    localparam int  MID_W    = P_WIDTH + 4;

    generate
        if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX) begin : g_badStage
            $error("keygen_mac_pipe: NUM_STAGE=%0d outside %0d..%0d",
                   NUM_STAGE, NUM_STAGE_MIN, NUM_STAGE_MAX);
        end
    endgenerate

    logic [A_WIDTH-1:0] a_q;
    logic [B_WIDTH-1:0] b_q;
    logic               valid_q, mode_q, first_q, last_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            mode_q  <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (ce) begin
            a_q     <= din0;
            b_q     <= din1;
            valid_q <= in_valid;
            mode_q  <= mode;
            first_q <= first;
            last_q  <= last;
        end
    end

    // Operands are widened to the full product width so one unsigned multiply
    // yields the correct two's complement result modulo 2^FW.
    logic [FW-1:0]      aExt, bExt, fullProd;
    logic [P_WIDTH-1:0] prodP;

    assign aExt     = A_SIGNED ? {{B_WIDTH{a_q[A_WIDTH-1]}}, a_q} : {{B_WIDTH{1'b0}}, a_q};
    assign bExt     = B_SIGNED ? {{A_WIDTH{b_q[B_WIDTH-1]}}, b_q} : {{A_WIDTH{1'b0}}, b_q};
    assign fullProd = aExt * bExt;

    generate
        if (P_WIDTH < FW) begin : g_wrap
            logic [FW-P_WIDTH-1:0] unusedHigh;
            assign unusedHigh = fullProd[FW-1:P_WIDTH];
            assign prodP      = fullProd[P_WIDTH-1:0];
        end else if (P_WIDTH == FW) begin : g_exact
            assign prodP = fullProd;
        end else begin : g_extend
            assign prodP = {{(P_WIDTH-FW){SIGN_EXT & fullProd[FW-1]}}, fullProd};
        end
    endgenerate

    logic [MID_W-1:0]   midIn, midOut;
    logic               stValid, stMode, stFirst, stLast;
    logic [P_WIDTH-1:0] stProd;

    assign midIn = {valid_q, mode_q, first_q, last_q, prodP};

    keygen_mul_delay #(
        .WIDTH (MID_W),
        .DEPTH (NUM_STAGE - 2)
    ) u_delay (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .d_i   (midIn),
        .q_o   (midOut)
    );

    assign {stValid, stMode, stFirst, stLast, stProd} = midOut;

    logic [P_WIDTH-1:0]   acc_q, acc_d, dout_q, dout_d, sum;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, outCount_q, outCount_d, cntNext;
    logic                 outValid_q, outValid_d;

    // A first beat restarts from zero; last emits the sum and clears the running state.
    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        dout_d     = dout_q;
        outCount_d = outCount_q;
        outValid_d = 1'b0;
        sum        = (stFirst ? '0 : acc_q) + stProd;
        cntNext    = satInc(stFirst ? '0 : cnt_q);
        if (stValid) begin
            if (stMode == MODE_MUL) begin
                outValid_d = 1'b1;
                dout_d     = stProd;
                outCount_d = CNT_WIDTH'(1);
            end else if (stLast) begin
                outValid_d = 1'b1;
                dout_d     = sum;
                outCount_d = cntNext;
                acc_d      = '0;
                cnt_d      = '0;
            end else begin
                acc_d = sum;
                cnt_d = cntNext;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            dout_q     <= '0;
            outCount_q <= '0;
            outValid_q <= 1'b0;
        end else if (ce) begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            outCount_q <= outCount_d;
            outValid_q <= outValid_d;
        end
    end

    assign out_valid = outValid_q;
    assign dout      = dout_q;
    assign out_count = outCount_q;

endmodule
